dff_16: RTL and testbench
=========================

Name: dff_16

Overview:
- 16-bit positive-edge D-type register (bank of 16 D flip-flops sharing one clock).
- Captures a 16-bit input word on every rising clock edge and presents it on the output until the next edge.
- Generic pipeline/holding register used wherever a full word must be delayed by exactly one clock.
- Synchronous, active-high reset forces the stored word to a fixed value.

Parameters:
- WIDTH, 16, data width in bits; all data ports are WIDTH wide.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the register on reset.

Ports:
- clk  input  1  clock; all state changes occur on its rising edge.
- rst  input  1  synchronous reset, active-high; sampled only on the rising edge of clk.
- in  input  WIDTH  data word to be captured.
- out  output  WIDTH  registered data word; driven directly from the flip-flops.
- Declaration order is out, clk, in, rst, so existing positional instances of the form (out, clk, in) still bind correctly.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- On every rising edge of clk:
  - if rst = 1, out <= RESET_VALUE;
  - else out <= in.
- rst has priority over in.
- Reset has no asynchronous effect. Asserting or deasserting rst between edges changes nothing until the next rising edge.
- Latency is exactly 1 clock. A value applied on in before rising edge k appears on out just after edge k and holds until edge k+1.
- No enable: the register loads on every edge. Holding a value requires holding in constant.
- All WIDTH bits are updated together on the same edge; there is no per-bit or partial update.
- out is a pure register output, with no combinational path from in or rst to out.
- Changes on in between edges do not affect out (no transparency; this is not a latch).
- Power-up: out is undefined (X in simulation) until the first rising edge. After that edge it holds either RESET_VALUE (rst=1) or the sampled in (rst=0).
- Reset mid-stream: the first edge with rst=1 loads RESET_VALUE, discarding the data sampled on that edge. The first edge with rst=0 after reset loads in normally; no extra bubble cycle is inserted.
- Setup/hold: in and rst must be stable around the rising edge. Benches change stimulus away from the edge, e.g. on the falling edge or half a period away.
- No X-propagation handling is required: X on in is captured as X.

Test Plan:
- Power-up/reset: clk period 10 ns; hold rst=1, in=16'hFFFF for two edges -> out=16'h0000 after the first edge and stays 0; out is X before the first edge.
- Basic capture: rst=0; apply in=0000, FFFF, 0000, FFFF, 0000, 0000, FFFF, FFFF, one word per period, changed mid-cycle -> out shows the same sequence delayed by one rising edge; FFFF holds across its two consecutive cycles.
- Pattern/bit independence: in=16'hA5A5, then 16'h5A5A, then 16'h8001 -> out equals each word exactly on the following edge, with no bit crosstalk.
- Mid-cycle glitch: with out=16'h1234, pulse in to 16'hFFFF and back to 16'h1234 entirely between edges -> out stays 16'h1234.
- Sync reset mid-operation: out=16'hBEEF; assert rst between edges -> out unchanged until the next edge, then 16'h0000. Deassert rst with in=16'h00FF -> out=16'h00FF on the following edge.
- Reset priority: rst=1 and in=16'hFFFF on the same edge -> out=16'h0000. Parameter check: RESET_VALUE=16'hC3C3 gives out=16'hC3C3 under the same stimulus.

Source files
------------

// File: rtl/dff_16.sv
// Word-wide positive-edge D register with synchronous active-high reset.
// Delays the input word by exactly one clock; the output comes straight from the flops.
module dff_16 #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic [WIDTH-1:0] in,
  input  logic             rst
);

  logic [WIDTH-1:0] data_reg;

  // One flop per bit; every bit shares the same clock edge and reset, so the word updates atomically.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg[gi] <= RESET_VALUE[gi];
        end else begin
          data_reg[gi] <= in[gi];
        end
      end
    end
  endgenerate

  assign out = data_reg;

endmodule

// File: tb/tb_dff_16.sv
// Self-checking bench for dff_16: table-driven vectors plus hand-written multi-cycle sequences.
// A second instance with a non-zero reset value shares the same stimulus.
module tb_dff_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in  = 16'hFFFF;
  logic [15:0] out_a;
  logic [15:0] out_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_16 dut_a (
    .out (out_a),
    .clk (clk),
    .in  (in),
    .rst (rst)
  );

  dff_16 #(.WIDTH(16), .RESET_VALUE(16'hC3C3)) dut_b (
    .out (out_b),
    .clk (clk),
    .in  (in),
    .rst (rst)
  );

  typedef struct {
    logic        rst;
    logic [15:0] in;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [0:15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s out=%h", name, act);
    end
  endtask

  // Drive inputs half a period before the edge, then sample 1 ns after it.
  task automatic step(input logic r, input logic [15:0] d);
    @(negedge clk);
    rst = r;
    in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'hFFFF, 16'h0000, 16'hC3C3};
    vecs[1]  = '{1'b1, 16'hFFFF, 16'h0000, 16'hC3C3};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[9]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[10] = '{1'b0, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    vecs[11] = '{1'b0, 16'h5A5A, 16'h5A5A, 16'h5A5A};
    vecs[12] = '{1'b0, 16'h8001, 16'h8001, 16'h8001};
    vecs[13] = '{1'b1, 16'hFFFF, 16'h0000, 16'hC3C3};
    vecs[14] = '{1'b0, 16'h7E81, 16'h7E81, 16'h7E81};
    vecs[15] = '{1'b0, 16'h1234, 16'h1234, 16'h1234};

    // First vector is applied at time 0 so the very first edge already sees rst=1.
    rst = vecs[0].rst;
    in  = vecs[0].in;
    @(posedge clk);
    #1;
    check("vec0_a", out_a, vecs[0].exp_a);
    check("vec0_b", out_b, vecs[0].exp_b);
    for (int i = 1; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].in);
      check($sformatf("vec%0d_a", i), out_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), out_b, vecs[i].exp_b);
    end

    // Glitch on in entirely between edges must not reach out.
    @(negedge clk);
    #1 in = 16'hFFFF;
    #2 in = 16'h1234;
    #1 check("glitch_between_edges", out_a, 16'h1234);
    @(posedge clk);
    #1 check("glitch_after_edge", out_a, 16'h1234);

    // Reset asserted mid-cycle takes effect only on the next edge.
    step(1'b0, 16'hBEEF);
    check("pre_reset_load", out_a, 16'hBEEF);
    @(negedge clk);
    rst = 1'b1;
    #2 check("reset_no_async_a", out_a, 16'hBEEF);
    check("reset_no_async_b", out_b, 16'hBEEF);
    @(posedge clk);
    #1 check("reset_sync_a", out_a, 16'h0000);
    check("reset_sync_b", out_b, 16'hC3C3);

    // Deassert with new data: no bubble cycle after reset.
    @(negedge clk);
    rst = 1'b0;
    in  = 16'h00FF;
    #2 check("deassert_no_async", out_a, 16'h0000);
    @(posedge clk);
    #1 check("post_reset_load_a", out_a, 16'h00FF);
    check("post_reset_load_b", out_b, 16'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
